// File: rtl/ecdsa_reg_bank.sv
// ecdsa_reg_bank: PIO register bank for the ECDSA engine.
// Provides NUM_CFG read/write configuration registers and a clk_div-paced
// request/response handshake toward the PIO bus. Defining the macro
// ECDSA_REG_FAIL_CNT_EN adds a saturating, clear-on-read verify-failure
// counter at offset NUM_CFG. Without it, evt_fail is ignored and that
// offset is unmapped.
module ecdsa_reg_bank #(
  parameter int                   PIO_NBITS  = 32,
  parameter int                   ADDR_NBITS = 4,
  parameter int                   NUM_CFG    = 4,
  parameter int                   REG_NBITS  = 32,
  parameter logic [REG_NBITS-1:0] RST_VAL    = '1,
  parameter int                   CNT_NBITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_div,
  input  logic                         reg_bs,
  input  logic                         reg_rd,
  input  logic                         reg_wr,
  input  logic [PIO_NBITS-1:0]         reg_addr,
  input  logic [PIO_NBITS-1:0]         reg_din,
  output logic                         pio_ack,
  output logic                         pio_rvalid,
  output logic [PIO_NBITS-1:0]         pio_rdata,
  input  logic                         evt_fail,
  output logic [NUM_CFG*REG_NBITS-1:0] cfg_out,
  output logic [NUM_CFG-1:0]           cfg_wr_stb
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                            state_q, state_d;
  logic                              op_rd_q, op_rd_d;
  logic [ADDR_NBITS-1:0]             off_q, off_d;
  logic [REG_NBITS-1:0]              data_q, data_d;
  logic [NUM_CFG-1:0][REG_NBITS-1:0] cfg_q, cfg_d;
  logic [NUM_CFG-1:0]                stb_q, stb_d;
  logic                              ack_q, ack_d;
  logic                              rvalid_q, rvalid_d;
  logic [PIO_NBITS-1:0]              rdata_q, rdata_d;

`ifdef ECDSA_REG_FAIL_CNT_EN
  logic [CNT_NBITS-1:0]              cnt_q, cnt_d;

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_NBITS-1:0] sat_inc(input logic [CNT_NBITS-1:0] v);
    return (&v) ? v : v + CNT_NBITS'(1);
  endfunction
`endif

  // Upper address bits are decoded by the fabric, upper data bits beyond
  // REG_NBITS are discarded, and evt_fail is dead when the counter is absent.
  logic unused_bits;
  assign unused_bits = ^{reg_addr, reg_din, evt_fail};

  // Next-state: capture a request, execute it on the PIO-rate edge, then
  // hold the response for one PIO period before releasing the bus.
  always_comb begin
    state_d  = state_q;
    op_rd_d  = op_rd_q;
    off_d    = off_q;
    data_d   = data_q;
    cfg_d    = cfg_q;
    stb_d    = '0;
    ack_d    = ack_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
`ifdef ECDSA_REG_FAIL_CNT_EN
    cnt_d    = evt_fail ? sat_inc(cnt_q) : cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reg_bs && (reg_rd || reg_wr)) begin
          // Read takes priority when both strobes are present.
          op_rd_d = reg_rd;
          off_d   = reg_addr[ADDR_NBITS-1:0];
          data_d  = reg_din[REG_NBITS-1:0];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (clk_div) begin
          state_d  = RESP;
          ack_d    = 1'b0;
          rvalid_d = 1'b0;
          rdata_d  = '0;
          if (op_rd_q) begin
            // Unmapped until a mapped target claims the offset below.
            ack_d = 1'b1;
            for (int i = 0; i < NUM_CFG; i++) begin
              if (int'(off_q) == i) begin
                ack_d                   = 1'b0;
                rvalid_d                = 1'b1;
                rdata_d[REG_NBITS-1:0]  = cfg_q[i];
              end
            end
`ifdef ECDSA_REG_FAIL_CNT_EN
            if (int'(off_q) == NUM_CFG) begin
              ack_d                   = 1'b0;
              rvalid_d                = 1'b1;
              rdata_d[CNT_NBITS-1:0]  = cnt_q;
              // Clear-on-read; a coincident failure event survives as 1.
              cnt_d = evt_fail ? CNT_NBITS'(1) : '0;
            end
`endif
          end else begin
            // Writes to the counter or unmapped offsets are acked but ignored.
            ack_d = 1'b1;
            for (int i = 0; i < NUM_CFG; i++) begin
              if (int'(off_q) == i) begin
                cfg_d[i] = data_q;
                stb_d[i] = 1'b1;
              end
            end
          end
        end
      end
      RESP: begin
        if (clk_div) begin
          ack_d    = 1'b0;
          rvalid_d = 1'b0;
          rdata_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage for FSM, response and config state; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_rd_q  <= 1'b0;
      off_q    <= '0;
      data_q   <= '0;
      cfg_q    <= {NUM_CFG{RST_VAL}};
      stb_q    <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef ECDSA_REG_FAIL_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_rd_q  <= op_rd_d;
      off_q    <= off_d;
      data_q   <= data_d;
      cfg_q    <= cfg_d;
      stb_q    <= stb_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef ECDSA_REG_FAIL_CNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign pio_ack    = ack_q;
  assign pio_rvalid = rvalid_q;
  assign pio_rdata  = rdata_q;
  assign cfg_out    = cfg_q;
  assign cfg_wr_stb = stb_q;

endmodule
